// File: rtl/Types.sv
// Shared widths and types for the raytracing scheduler slice.
// The `define block holds the fixed-point and bus widths. The package below
// re-exports them as localparams, so other files only need Types::.
// The package also holds the default frame geometry, the colour and sphere
// types, and the scheduler state encoding.
`ifndef TYPES_SV
`define TYPES_SV

`define FP_B        4
`define COORD_B     16
`define COLOR_B     12
`define PX_Y_B      12
`define PX_Y_SQRD_B 24
`define DOT_Y_B     28
`define S_Y_SQRD_B  32
`define FB_ADDR_B   19

package Types;

  localparam int FP_B        = `FP_B;
  localparam int COORD_B     = `COORD_B;
  localparam int COLOR_B     = `COLOR_B;
  localparam int PX_Y_B      = `PX_Y_B;
  localparam int PX_Y_SQRD_B = `PX_Y_SQRD_B;
  localparam int DOT_Y_B     = `DOT_Y_B;
  localparam int S_Y_SQRD_B  = `S_Y_SQRD_B;
  localparam int FB_ADDR_B   = `FB_ADDR_B;

  // Default frame geometry: N_WORKERS * JOBS_SUBDIVISION must equal COLS.
  localparam int N_WORKERS        = 10;
  localparam int JOBS_SUBDIVISION = 64;
  localparam int COLS             = 640;
  localparam int ROWS             = 480;

  typedef logic [COLOR_B-1:0] Color;

  typedef struct packed {
    logic signed [COORD_B-1:0] x;
    logic signed [COORD_B-1:0] y;
    logic signed [COORD_B-1:0] z;
    logic signed [COORD_B-1:0] r;
  } Sphere;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ROW_SETUP = 3'd1,
    S_LAUNCH    = 3'd2,
    S_WAIT_RISE = 3'd3,
    S_WAIT_FALL = 3'd4,
    S_DRAIN     = 3'd5,
    S_DONE      = 3'd6
  } sched_state_t;

endpackage

`endif

// File: rtl/raytracing_drain_ctrl.sv
// Row drain engine: streams one row of finished pixels into the framebuffer.
// Column c = job*N_WORKERS + worker. The worker counter wraps fastest, so a
// pair of counters walks columns in ascending order without a divider. The
// address is one frame-wide counter: consecutive rows are contiguous in the
// framebuffer, so no row*COLS multiply is needed.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clear          restart the framebuffer address at 0 (new frame)
//   start          begin draining a row (counters back to column 0)
//   worker_buffer  per-worker pixel results, read only while draining
//   fb_we/fb_addr/fb_data/fb_ready  valid/ready framebuffer write port
//   row_done       pulses in the cycle the last column of the row transfers
module raytracing_drain_ctrl #(
  parameter int N_WORKERS        = Types::N_WORKERS,
  parameter int JOBS_SUBDIVISION = Types::JOBS_SUBDIVISION
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               clear,
  input  logic                                               start,
  input  Types::Color [N_WORKERS-1:0][JOBS_SUBDIVISION-1:0]  worker_buffer,
  output logic                                               fb_we,
  output logic [Types::FB_ADDR_B-1:0]                        fb_addr,
  output Types::Color                                        fb_data,
  input  logic                                               fb_ready,
  output logic                                               row_done
);

  localparam int WK_W = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
  localparam int JB_W = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;
  localparam int AW   = Types::FB_ADDR_B;

  logic            active_reg;
  logic [WK_W-1:0] worker_reg;
  logic [JB_W-1:0] job_reg;
  logic [AW-1:0]   addr_reg;
  logic            xfer;
  logic            last_worker;
  logic            last_job;

  assign xfer        = active_reg && fb_ready;
  assign last_worker = (worker_reg == WK_W'(N_WORKERS - 1));
  assign last_job    = (job_reg == JB_W'(JOBS_SUBDIVISION - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg <= 1'b0;
      worker_reg <= '0;
      job_reg    <= '0;
      addr_reg   <= '0;
    end else begin
      if (clear) begin
        addr_reg <= '0;
      end
      if (start) begin
        active_reg <= 1'b1;
        worker_reg <= '0;
        job_reg    <= '0;
      end else if (xfer) begin
        // Nothing moves while fb_ready is low, so address and data hold.
        addr_reg <= addr_reg + AW'(1);
        if (last_worker) begin
          worker_reg <= '0;
          if (last_job) begin
            job_reg    <= '0;
            active_reg <= 1'b0;
          end else begin
            job_reg <= job_reg + JB_W'(1);
          end
        end else begin
          worker_reg <= worker_reg + WK_W'(1);
        end
      end
    end
  end

  assign fb_we    = active_reg;
  assign fb_addr  = addr_reg;
  // Selected by registered counters only; stable for the whole stall.
  assign fb_data  = worker_buffer[worker_reg][job_reg];
  assign row_done = xfer && last_worker && last_job;

endmodule

// File: rtl/raytracing_scheduler.sv
// Frame scheduler for a bank of Raytracing_Worker instances.
// For each row it computes the per-row geometry terms once, then launches all
// workers together. It waits until every worker has raised and then dropped
// busy. Activate stays high until the last worker finishes, so early
// finishers stay in FINISHED and are not relaunched. Finally it drains the
// row into the framebuffer through raytracing_drain_ctrl.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   frame_start, sphere_i          frame request and scene sphere (latched)
//   sphere_o, pixel_y, pixel_y_sqrd, doty_r, sphere_y_sqrd
//                                  per-row broadcast to workers
//   activate, pixel_start_x        per-worker launch and fixed x origin
//   worker_busy, worker_buffer     per-worker status and results
//   fb_we, fb_addr, fb_data, fb_ready  framebuffer write port
//   frame_busy, frame_done         frame status
//   frame_cycles                   cycle count of the last frame
// Build option: define RT_SCHED_PERF_EN to enable the frame_cycles counter.
// Otherwise frame_cycles is tied to 0.
module raytracing_scheduler #(
  parameter int N_WORKERS        = Types::N_WORKERS,
  parameter int JOBS_SUBDIVISION = Types::JOBS_SUBDIVISION,
  parameter int COLS             = Types::COLS,
  parameter int ROWS             = Types::ROWS
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               frame_start,
  input  Types::Sphere                                       sphere_i,
  output Types::Sphere                                       sphere_o,
  output logic signed [Types::PX_Y_B-1:0]                    pixel_y,
  output logic signed [Types::PX_Y_SQRD_B-1:0]               pixel_y_sqrd,
  output logic signed [Types::DOT_Y_B-1:0]                   doty_r,
  output logic signed [Types::S_Y_SQRD_B-1:0]                sphere_y_sqrd,
  output logic [N_WORKERS-1:0]                               activate,
  output logic [N_WORKERS-1:0][11:0]                         pixel_start_x,
  input  logic [N_WORKERS-1:0]                               worker_busy,
  input  Types::Color [N_WORKERS-1:0][JOBS_SUBDIVISION-1:0]  worker_buffer,
  output logic                                               fb_we,
  output logic [Types::FB_ADDR_B-1:0]                        fb_addr,
  output Types::Color                                        fb_data,
  input  logic                                               fb_ready,
  output logic                                               frame_busy,
  output logic                                               frame_done,
  output logic [31:0]                                        frame_cycles
);

  localparam int PYB   = Types::PX_Y_B;
  localparam int PYSB  = Types::PX_Y_SQRD_B;
  localparam int DYB   = Types::DOT_Y_B;
  localparam int SYB   = Types::S_Y_SQRD_B;
  localparam int FPB   = Types::FP_B;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  Types::sched_state_t              state_reg;
  Types::Sphere                     sphere_reg;
  logic [ROW_W-1:0]                 row_reg;
  logic signed [PYB-1:0]            pixel_y_reg;
  logic signed [PYSB-1:0]           pixel_y_sqrd_reg;
  logic signed [DYB-1:0]            doty_reg;
  logic signed [SYB-1:0]            sphere_y_sqrd_reg;
  logic [N_WORKERS-1:0]             activate_reg;
  logic                             frame_busy_reg;
  logic                             frame_done_reg;
  logic                             drain_start_reg;
  logic                             drain_clear_reg;
  logic                             row_done;
  logic signed [PYB-1:0]            pixel_y_next;

  // Row 0 is the top of the image: y counts down from ROWS/2.
  assign pixel_y_next = PYB'(ROWS / 2) - PYB'(row_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= Types::S_IDLE;
      sphere_reg        <= '0;
      row_reg           <= '0;
      pixel_y_reg       <= '0;
      pixel_y_sqrd_reg  <= '0;
      doty_reg          <= '0;
      sphere_y_sqrd_reg <= '0;
      activate_reg      <= '0;
      frame_busy_reg    <= 1'b0;
      frame_done_reg    <= 1'b0;
      drain_start_reg   <= 1'b0;
      drain_clear_reg   <= 1'b0;
    end else begin
      drain_start_reg <= 1'b0;
      drain_clear_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      case (state_reg)
        Types::S_IDLE: begin
          if (frame_start) begin
            sphere_reg      <= sphere_i;
            row_reg         <= '0;
            drain_clear_reg <= 1'b1;
            frame_busy_reg  <= 1'b1;
            state_reg       <= Types::S_ROW_SETUP;
          end
        end
        Types::S_ROW_SETUP: begin
          pixel_y_reg       <= pixel_y_next;
          pixel_y_sqrd_reg  <= PYSB'(pixel_y_next) * PYSB'(pixel_y_next);
          doty_reg          <= DYB'(pixel_y_next) * DYB'(sphere_reg.y);
          sphere_y_sqrd_reg <= (SYB'(sphere_reg.y) * SYB'(sphere_reg.y)) >>> FPB;
          state_reg         <= Types::S_LAUNCH;
        end
        Types::S_LAUNCH: begin
          activate_reg <= '1;
          state_reg    <= Types::S_WAIT_RISE;
        end
        Types::S_WAIT_RISE: begin
          if (worker_busy == '1) begin
            state_reg <= Types::S_WAIT_FALL;
          end
        end
        Types::S_WAIT_FALL: begin
          // Only release activate once the slowest worker is done.
          if (worker_busy == '0) begin
            activate_reg    <= '0;
            drain_start_reg <= 1'b1;
            state_reg       <= Types::S_DRAIN;
          end
        end
        Types::S_DRAIN: begin
          if (row_done) begin
            if (row_reg == ROW_W'(ROWS - 1)) begin
              frame_done_reg <= 1'b1;
              state_reg      <= Types::S_DONE;
            end else begin
              row_reg   <= row_reg + ROW_W'(1);
              state_reg <= Types::S_ROW_SETUP;
            end
          end
        end
        Types::S_DONE: begin
          frame_busy_reg <= 1'b0;
          state_reg      <= Types::S_IDLE;
        end
        default: begin
          state_reg <= Types::S_IDLE;
        end
      endcase
    end
  end

  raytracing_drain_ctrl #(
    .N_WORKERS        (N_WORKERS),
    .JOBS_SUBDIVISION (JOBS_SUBDIVISION)
  ) u_drain (
    .clk           (clk),
    .rst           (rst),
    .clear         (drain_clear_reg),
    .start         (drain_start_reg),
    .worker_buffer (worker_buffer),
    .fb_we         (fb_we),
    .fb_addr       (fb_addr),
    .fb_data       (fb_data),
    .fb_ready      (fb_ready),
    .row_done      (row_done)
  );

  for (genvar gi = 0; gi < N_WORKERS; gi++) begin : g_start_x
    assign pixel_start_x[gi] = 12'(gi) - 12'(COLS / 2);
  end

  assign sphere_o      = sphere_reg;
  assign pixel_y       = pixel_y_reg;
  assign pixel_y_sqrd  = pixel_y_sqrd_reg;
  assign doty_r        = doty_reg;
  assign sphere_y_sqrd = sphere_y_sqrd_reg;
  assign activate      = activate_reg;
  assign frame_busy    = frame_busy_reg;
  assign frame_done    = frame_done_reg;

`ifdef RT_SCHED_PERF_EN
  logic [31:0] cycle_cnt_reg;
  logic [31:0] frame_cycles_reg;

  // Counts the accept cycle plus every busy cycle up to and including DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_reg    <= '0;
      frame_cycles_reg <= '0;
    end else begin
      if (state_reg == Types::S_IDLE && frame_start) begin
        cycle_cnt_reg <= 32'd1;
      end else if (state_reg != Types::S_IDLE) begin
        cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      end
      if (state_reg == Types::S_DONE) begin
        frame_cycles_reg <= cycle_cnt_reg + 32'd1;
      end
    end
  end

  assign frame_cycles = frame_cycles_reg;
`else
  assign frame_cycles = '0;
`endif

endmodule

// File: tb/tb_raytracing_scheduler.sv
module tb_raytracing_scheduler;

  localparam int NW   = 10;
  localparam int JS   = 64;
  localparam int COLS = 640;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 2-row frames, modelled workers. DUT B: 480 rows, workers never busy.
  logic rst_a = 1'b1, rst_b = 1'b1, fs_a = 1'b0, fs_b = 1'b0, fb_ready = 1'b1;
  Types::Sphere sph_a = '0, sph_b = '0, sph_o_a, sph_o_b;
  logic signed [11:0] py_a, py_b;
  logic signed [23:0] pys_a, pys_b;
  logic signed [27:0] dy_a, dy_b;
  logic signed [31:0] sy_a, sy_b;
  logic [NW-1:0] act_a, act_b, busy_a;
  logic [NW-1:0] busy_b = '0;
  logic [NW-1:0][11:0] psx_a, psx_b;
  Types::Color [NW-1:0][JS-1:0] wbuf;
  logic we_a, we_b, fbusy_a, fbusy_b, fdone_a, fdone_b;
  logic fb_ready_b = 1'b1;
  logic [18:0] addr_a, addr_b;
  Types::Color data_a, data_b;
  logic [31:0] cyc_a, cyc_b;

  for (genvar gw = 0; gw < NW; gw++) begin : g_w
    for (genvar gj = 0; gj < JS; gj++) begin : g_j
      assign wbuf[gw][gj] = {4'(gw), 4'(gj), 4'h0};
    end
  end

  raytracing_scheduler #(.N_WORKERS(NW), .JOBS_SUBDIVISION(JS), .COLS(COLS), .ROWS(2)) dut_a (
    .clk(clk), .rst(rst_a), .frame_start(fs_a), .sphere_i(sph_a), .sphere_o(sph_o_a),
    .pixel_y(py_a), .pixel_y_sqrd(pys_a), .doty_r(dy_a), .sphere_y_sqrd(sy_a),
    .activate(act_a), .pixel_start_x(psx_a), .worker_busy(busy_a), .worker_buffer(wbuf),
    .fb_we(we_a), .fb_addr(addr_a), .fb_data(data_a), .fb_ready(fb_ready),
    .frame_busy(fbusy_a), .frame_done(fdone_a), .frame_cycles(cyc_a));

  raytracing_scheduler #(.N_WORKERS(NW), .JOBS_SUBDIVISION(JS), .COLS(COLS), .ROWS(480)) dut_b (
    .clk(clk), .rst(rst_b), .frame_start(fs_b), .sphere_i(sph_b), .sphere_o(sph_o_b),
    .pixel_y(py_b), .pixel_y_sqrd(pys_b), .doty_r(dy_b), .sphere_y_sqrd(sy_b),
    .activate(act_b), .pixel_start_x(psx_b), .worker_busy(busy_b), .worker_buffer(wbuf),
    .fb_we(we_b), .fb_addr(addr_b), .fb_data(data_b), .fb_ready(fb_ready_b),
    .frame_busy(fbusy_b), .frame_done(fdone_b), .frame_cycles(cyc_b));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Worker model: READY(0) -> BUSY(1) for busy_len cycles -> FINISHED(2);
  // any cycle without activate returns it to READY.
  int busy_len[NW];
  int wcnt[NW];
  logic [1:0] wst[NW];
  initial for (int w = 0; w < NW; w++) begin wst[w] = 2'd0; wcnt[w] = 0; busy_len[w] = 5; end

  always @(posedge clk) begin
    for (int w = 0; w < NW; w++) begin
      if (!act_a[w]) wst[w] <= 2'd0;
      else if (wst[w] == 2'd0) begin wst[w] <= 2'd1; wcnt[w] <= busy_len[w]; end
      else if (wst[w] == 2'd1) begin
        if (wcnt[w] <= 1) wst[w] <= 2'd2;
        else wcnt[w] <= wcnt[w] - 1;
      end
    end
  end
  for (genvar gw = 0; gw < NW; gw++) begin : g_busy
    assign busy_a[gw] = (wst[gw] == 2'd1);
  end

  // Reference pixel for column c: worker c%NW, job c/NW.
  function automatic Types::Color exp_pix(input int c);
    int w;
    int j;
    w = c % NW;
    j = c / NW;
    return {w[3:0], j[3:0], 4'h0};
  endfunction

  // Scoreboard state.
  int exp_idx = 0, wr_cnt = 0, done_cnt = 0, act_cycles = 0, c;
  bit stall_prev = 0, workers_done = 0, chk_act_en = 0;
  logic [18:0] hold_addr;
  Types::Color hold_data, data_c23 = '0;
  logic [NW-1:0] busy_prev = '0;

  always @(negedge clk) begin
    if (rst_a) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_we", 64'(we_a), 64'd1);
        chk("stall_addr", 64'(addr_a), 64'(hold_addr));
        chk("stall_data", 64'(data_a), 64'(hold_data));
      end
      if (we_a) chk("no_buffer_read_while_active", 64'(act_a), 64'd0);
      if (chk_act_en && busy_a != '0) chk("activate_held", 64'(act_a), 64'(10'h3FF));
      if (we_a && fb_ready) begin
        c = exp_idx % COLS;
        chk("fb_addr", 64'(addr_a), 64'(exp_idx));
        chk("fb_data", 64'(data_a), 64'(exp_pix(c)));
        if (c == 0) chk("drain_after_fall", 64'(workers_done), 64'd1);
        if (c == 23) data_c23 = data_a;
        exp_idx++;
        wr_cnt++;
      end
      if (fdone_a) begin
        done_cnt++;
        chk("done_after_writes", 64'(wr_cnt), 64'd1280);
      end
      if (act_a == '1) act_cycles++;
      stall_prev = we_a && !fb_ready;
      hold_addr  = addr_a;
      hold_data  = data_a;
      if (busy_prev != '0 && busy_a == '0) workers_done = 1;
      if (busy_prev == '0 && busy_a != '0) workers_done = 0;
      busy_prev = busy_a;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_a();
    fs_a = 1'b1;
    step();
    fs_a = 1'b0;
  endtask

  Types::Sphere sph_ref;

  initial begin
    repeat (3) step();
    // Reset state of both instances.
    chk("rst_activate", 64'(act_a), 64'd0);
    chk("rst_fb_we", 64'(we_a), 64'd0);
    chk("rst_frame_busy", 64'(fbusy_a), 64'd0);
    chk("rst_frame_done", 64'(fdone_a), 64'd0);
    chk("rst_pixel_y", 64'(py_b), 64'd0);
    chk("rst_sphere_o", 64'(sph_o_b), 64'd0);
    chk("rst_doty", 64'(dy_b), 64'd0);
    chk("frame_cycles_off", 64'(cyc_a), 64'd0);
    chk("pixel_start_x3", 64'(psx_a[3]), 64'h0EC3);
    rst_a = 1'b0;
    rst_b = 1'b0;
    step();

    // Row 0 setup on the 480-row instance with sphere.y = 16.
    sph_b = '{x: 16'sd1, y: 16'sd16, z: 16'sd3, r: 16'sd5};
    sph_ref = sph_b;
    fs_b = 1'b1;
    step();
    fs_b = 1'b0;
    repeat (4) step();
    chk("pixel_y_row0", 64'(py_b), 64'd240);
    chk("pixel_y_sqrd_row0", 64'(pys_b), 64'd57600);
    chk("doty_row0", 64'(dy_b), 64'd3840);
    chk("sphere_y_sqrd", 64'(sy_b), 64'd16);
    chk("launch_all", 64'(act_b), 64'(10'h3FF));
    chk("busy_b", 64'(fbusy_b), 64'd1);
    sph_b = '{x: 16'sd7, y: 16'sd99, z: 16'sd8, r: 16'sd9};
    fs_b = 1'b1;
    step();
    fs_b = 1'b0;
    repeat (3) step();
    chk("sphere_o_held", 64'(sph_o_b), 64'(sph_ref));
    chk("pixel_y_held", 64'(py_b), 64'd240);
    rst_b = 1'b1;
    step();
    chk("rst_b_activate", 64'(act_b), 64'd0);
    rst_b = 1'b0;

    // Frame 1: staggered busy, stall at column 100, ignored frame_start.
    for (int w = 0; w < NW; w++) busy_len[w] = 20;
    busy_len[0] = 3;
    busy_len[9] = 40;
    exp_idx = 0; wr_cnt = 0; done_cnt = 0; act_cycles = 0;
    chk_act_en = 1;
    start_a();
    for (int i = 0; i < 4000 && !(we_a && addr_a == 19'd100); i++) step();
    chk("reach_col100", 64'(we_a && addr_a == 19'd100), 64'd1);
    fb_ready = 1'b0;
    repeat (7) step();
    fb_ready = 1'b1;
    start_a();
    for (int i = 0; i < 6000 && done_cnt == 0; i++) step();
    repeat (3) step();
    chk("f1_writes", 64'(wr_cnt), 64'd1280);
    chk("f1_done_pulses", 64'(done_cnt), 64'd1);
    chk("f1_idle", 64'(fbusy_a), 64'd0);
    chk("col23_data", 64'(data_c23), 64'h320);
    chk("act_hold_len", 64'(act_cycles >= 82), 64'd1);

    // Frame 2: reset at column 300 of row 1.
    for (int w = 0; w < NW; w++) busy_len[w] = 5;
    exp_idx = 0; wr_cnt = 0; done_cnt = 0;
    start_a();
    for (int i = 0; i < 4000 && !(we_a && addr_a == 19'd940); i++) step();
    chk("reach_row1_col300", 64'(we_a && addr_a == 19'd940), 64'd1);
    chk_act_en = 0;
    rst_a = 1'b1;
    step();
    chk("abort_activate", 64'(act_a), 64'd0);
    chk("abort_fb_we", 64'(we_a), 64'd0);
    chk("abort_busy", 64'(fbusy_a), 64'd0);
    rst_a = 1'b0;
    repeat (2) step();

    // Frame 3: plain 5-cycle workers, restarts at address 0.
    exp_idx = 0; wr_cnt = 0; done_cnt = 0;
    chk_act_en = 1;
    start_a();
    for (int i = 0; i < 6000 && !we_a; i++) step();
    chk("restart_addr0", 64'(addr_a), 64'd0);
    for (int i = 0; i < 6000 && done_cnt == 0; i++) step();
    repeat (3) step();
    chk("f3_writes", 64'(wr_cnt), 64'd1280);
    chk("f3_last_addr", 64'(exp_idx), 64'd1280);
    chk("f3_done_pulses", 64'(done_cnt), 64'd1);
    chk("f3_idle", 64'(fbusy_a), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
